// File: rtl/line_buf_sync_fifo_if.sv
// Write/read handshake bundle for the line-buffer FIFO.
`timescale 1ns/1ps
interface line_buf_sync_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              wr_full;
    logic              almost_full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_empty;
    logic              almost_empty;
    logic [ADDR_W:0]   water_level;
    logic              line_rdy;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, almost_full, rd_data, rd_valid, rd_empty,
        input  almost_empty, water_level, line_rdy, overflow, underflow
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, almost_full, rd_data, rd_valid, rd_empty,
        output almost_empty, water_level, line_rdy, overflow, underflow
    );
endinterface

// File: rtl/line_buf_sync_fifo.sv
// Single-clock line-buffer FIFO with level, threshold, line and error flags.
`timescale 1ns/1ps
module line_buf_sync_fifo #(
    parameter int DATA_W           = 8,
    parameter int ADDR_W           = 10,
    parameter int OUTPUT_REG       = 0,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter int LINE_LEN         = 640
) (
    input logic clk,
    input logic tb_rst,
    line_buf_sync_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_X = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_L = ALMOST_FULL_NUM[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_L = ALMOST_EMPTY_NUM[ADDR_W:0];
    localparam logic [ADDR_W:0] LL_L = LINE_LEN[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [ADDR_W:0]   level, level_nxt;
    logic              wr_acc, rd_acc;
    logic              full, empty, afull, aempty, line, ovf, unf;
    logic [DATA_W-1:0] s1_data, out_data;
    logic              s1_valid, out_valid;

    always_comb begin
        wr_acc     = bus.wr_en & ~full;
        rd_acc     = bus.rd_en & ~empty;
        wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, wr_acc};
        rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, rd_acc};
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
            line   <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            // Full when pointers differ only in the wrap bit.
            full   <= (wr_ptr_nxt ^ rd_ptr_nxt) == FULL_X;
            empty  <= wr_ptr_nxt == rd_ptr_nxt;
            afull  <= level_nxt >= AF_L;
            aempty <= level_nxt <= AE_L;
            line   <= level_nxt >= LL_L;
            ovf    <= ovf | (bus.wr_en & full);
            unf    <= unf | (bus.rd_en & empty);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) s1_data <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] s2_data;
        logic              s2_valid;
        always_ff @(posedge clk or posedge tb_rst) begin
            if (tb_rst) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_data <= s1_data;
            end
        end
        assign out_data  = s2_data;
        assign out_valid = s2_valid;
    end else begin : g_direct
        assign out_data  = s1_data;
        assign out_valid = s1_valid;
    end

    assign bus.wr_full      = full;
    assign bus.almost_full  = afull;
    assign bus.rd_empty     = empty;
    assign bus.almost_empty = aempty;
    assign bus.water_level  = level;
    assign bus.line_rdy     = line;
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;
    assign bus.rd_data      = out_data;
    assign bus.rd_valid     = out_valid;
endmodule

// File: tb/tb_line_buf_sync_fifo.sv
// Directed bench for line_buf_sync_fifo, both output-register modes side by side.
`timescale 1ns/1ps
module tb_line_buf_sync_fifo;
    logic       clk = 1'b0;
    logic       tb_rst = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    line_buf_sync_fifo_if #(.DATA_W(8), .ADDR_W(10)) b0 ();
    line_buf_sync_fifo_if #(.DATA_W(8), .ADDR_W(10)) b1 ();

    assign b0.wr_data = wr_data;
    assign b0.wr_en   = wr_en;
    assign b0.rd_en   = rd_en;
    assign b1.wr_data = wr_data;
    assign b1.wr_en   = wr_en;
    assign b1.rd_en   = rd_en;

    line_buf_sync_fifo #(
        .DATA_W(8), .ADDR_W(10), .OUTPUT_REG(0),
        .ALMOST_FULL_NUM(1020), .ALMOST_EMPTY_NUM(4), .LINE_LEN(640)
    ) u0 (.clk(clk), .tb_rst(tb_rst), .bus(b0));

    line_buf_sync_fifo #(
        .DATA_W(8), .ADDR_W(10), .OUTPUT_REG(1),
        .ALMOST_FULL_NUM(1020), .ALMOST_EMPTY_NUM(4), .LINE_LEN(640)
    ) u1 (.clk(clk), .tb_rst(tb_rst), .bus(b1));

    always #5 clk = ~clk;

    // rd_data, rd_valid, rd_empty, almost_empty, wr_full, almost_full,
    // line_rdy, water_level, overflow, underflow
    localparam logic [26:0] RST_ST = {8'h00, 6'b011000, 11'd0, 2'b00};
    logic [26:0] st0, st1;
    assign st0 = {b0.rd_data, b0.rd_valid, b0.rd_empty, b0.almost_empty,
                  b0.wr_full, b0.almost_full, b0.line_rdy, b0.water_level,
                  b0.overflow, b0.underflow};
    assign st1 = {b1.rd_data, b1.rd_valid, b1.rd_empty, b1.almost_empty,
                  b1.wr_full, b1.almost_full, b1.line_rdy, b1.water_level,
                  b1.overflow, b1.underflow};

    function automatic logic [7:0] pat(input int k);
        logic [11:0] kk;
        kk = 12'(k);
        return kk[7:0] ^ {kk[11:8], kk[11:8]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 tb_rst = 1'b1;
        #5 tb_rst = 1'b0;
    endtask

    task automatic test_reset;
        tb_rst = 1'b1;
        #199;
        n_cmp++;
        if (st0 !== RST_ST) begin
            n_err++;
            $display("FAIL reset_r0 got %h want %h", st0, RST_ST);
        end
        n_cmp++;
        if (st1 !== RST_ST) begin
            n_err++;
            $display("FAIL reset_r1 got %h want %h", st1, RST_ST);
        end
        #1 tb_rst = 1'b0;
    endtask

    task automatic test_fill;
        int lvl;
        logic [5:0] ef, gf;
        for (int i = 0; i < 1025; i++) begin
            wr_en = 1'b1;
            wr_data = 8'hFF - 8'(i);
            step();
            lvl = (i + 1 > 1024) ? 1024 : i + 1;
            n_cmp++;
            if (b0.water_level !== 11'(lvl) || b1.water_level !== 11'(lvl)) begin
                n_err++;
                $display("FAIL fill_level w%0d got %0d/%0d want %0d",
                         i + 1, b0.water_level, b1.water_level, lvl);
            end
            ef = {lvl == 1024, lvl >= 1020, lvl <= 4, lvl >= 640,
                  i + 1 > 1024, 1'b0};
            gf = {b0.wr_full, b0.almost_full, b0.almost_empty, b0.line_rdy,
                  b0.overflow, b0.underflow};
            n_cmp++;
            if (gf !== ef) begin
                n_err++;
                $display("FAIL fill_flags w%0d got %b want %b", i + 1, gf, ef);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_drain;
        int c0 = 0;
        int c1 = 0;
        logic [8:0] e0, e1;
        for (int j = 0; j < 1025; j++) begin
            rd_en = 1'b1;
            step();
            e0 = (j < 1024) ? {1'b1, 8'hFF - 8'(j)} : 9'h000;
            e1 = (j >= 1) ? {1'b1, 8'hFF - 8'(j - 1)} : 9'h000;
            n_cmp++;
            if ({b0.rd_valid, b0.rd_data} !== e0) begin
                n_err++;
                $display("FAIL drain_r0 r%0d got %h want %h",
                         j, {b0.rd_valid, b0.rd_data}, e0);
            end
            n_cmp++;
            if ({b1.rd_valid, b1.rd_data} !== e1) begin
                n_err++;
                $display("FAIL drain_r1 r%0d got %h want %h",
                         j, {b1.rd_valid, b1.rd_data}, e1);
            end
            n_cmp++;
            if (b0.underflow !== (j == 1024)) begin
                n_err++;
                $display("FAIL drain_unf r%0d got %b want %b",
                         j, b0.underflow, j == 1024);
            end
            if (b0.rd_valid) c0++;
            if (b1.rd_valid) c1++;
        end
        rd_en = 1'b0;
        step();
        n_cmp++;
        if ({b1.rd_valid, b1.rd_data} !== 9'h000) begin
            n_err++;
            $display("FAIL drain_tail_r1 got %h want 000", {b1.rd_valid, b1.rd_data});
        end
        if (b1.rd_valid) c1++;
        n_cmp++;
        if (c0 != 1024 || c1 != 1024) begin
            n_err++;
            $display("FAIL drain_vcount got %0d/%0d want 1024", c0, c1);
        end
        n_cmp++;
        if ({b0.rd_empty, b0.almost_empty, b0.underflow, b1.underflow,
             b0.water_level} !== {4'b1111, 11'd0}) begin
            n_err++;
            $display("FAIL drain_end got %b%b%b%b lvl %0d want 1111 lvl 0",
                     b0.rd_empty, b0.almost_empty, b0.underflow,
                     b1.underflow, b0.water_level);
        end
    endtask

    task automatic test_simultaneous;
        rst_pulse();
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_cmp++;
        if ({b0.water_level, b0.underflow, b0.overflow, b0.rd_valid,
             b0.rd_empty} !== {11'd1, 4'b1000}) begin
            n_err++;
            $display("FAIL simul_empty lvl %0d u%b o%b v%b e%b want lvl 1 u1 o0 v0 e0",
                     b0.water_level, b0.underflow, b0.overflow,
                     b0.rd_valid, b0.rd_empty);
        end
        rst_pulse();
        for (int i = 0; i < 1024; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h3C ^ 8'(i);
            step();
        end
        wr_data = 8'hEE;
        rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_cmp++;
        if ({b0.water_level, b0.overflow, b0.underflow, b0.wr_full}
            !== {11'd1023, 3'b100}) begin
            n_err++;
            $display("FAIL simul_full lvl %0d o%b u%b f%b want lvl 1023 o1 u0 f0",
                     b0.water_level, b0.overflow, b0.underflow, b0.wr_full);
        end
        n_cmp++;
        if ({b0.rd_valid, b0.rd_data} !== 9'h13C) begin
            n_err++;
            $display("FAIL simul_rd_r0 got %h want 13c", {b0.rd_valid, b0.rd_data});
        end
        step();
        n_cmp++;
        if ({b1.rd_valid, b1.rd_data} !== 9'h13C) begin
            n_err++;
            $display("FAIL simul_rd_r1 got %h want 13c", {b1.rd_valid, b1.rd_data});
        end
    endtask

    task automatic test_line_wrap;
        int wc = 0;
        int rq = 0;
        int r0 = 0;
        int r1 = 0;
        int lvl = 0;
        rst_pulse();
        for (int cyc = 0; cyc < 4000 && (r0 < 3000 || r1 < 3000); cyc++) begin
            wr_en = wc < 3000;
            wr_data = pat(wc);
            rd_en = (wc >= 640) && (rq < 3000);
            step();
            if (wr_en) begin
                wc++;
                lvl++;
            end
            if (rd_en) begin
                rq++;
                lvl--;
            end
            n_cmp++;
            if ({b0.water_level, b0.line_rdy} !== {11'(lvl), lvl >= 640}) begin
                n_err++;
                $display("FAIL line_level c%0d got %0d/%b want %0d/%b",
                         cyc, b0.water_level, b0.line_rdy, lvl, lvl >= 640);
            end
            if (b0.rd_valid === 1'b1) begin
                n_cmp++;
                if (b0.rd_data !== pat(r0)) begin
                    n_err++;
                    $display("FAIL wrap_r0 #%0d got %h want %h", r0, b0.rd_data, pat(r0));
                end
                r0++;
            end
            if (b1.rd_valid === 1'b1) begin
                n_cmp++;
                if (b1.rd_data !== pat(r1)) begin
                    n_err++;
                    $display("FAIL wrap_r1 #%0d got %h want %h", r1, b1.rd_data, pat(r1));
                end
                r1++;
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_cmp++;
        if (r0 != 3000 || r1 != 3000) begin
            n_err++;
            $display("FAIL wrap_count got %0d/%0d want 3000", r0, r1);
        end
        n_cmp++;
        if ({b0.overflow, b0.underflow, b1.overflow, b1.underflow,
             b0.rd_empty} !== 5'b00001) begin
            n_err++;
            $display("FAIL wrap_flags got %b%b%b%b%b want 00001",
                     b0.overflow, b0.underflow, b1.overflow,
                     b1.underflow, b0.rd_empty);
        end
    endtask

    task automatic test_mid_reset;
        rst_pulse();
        for (int k = 0; k < 500; k++) begin
            wr_en = 1'b1;
            wr_data = 8'h80 | 8'(k & 127);
            step();
        end
        wr_data = 8'h11;
        rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_cmp++;
        if ({b0.rd_valid, b0.rd_data, b0.water_level} !== {9'h180, 11'd500}) begin
            n_err++;
            $display("FAIL mid_pre got v%b d%h lvl %0d want v1 d80 lvl 500",
                     b0.rd_valid, b0.rd_data, b0.water_level);
        end
        #1 tb_rst = 1'b1;
        #0.5;
        n_cmp++;
        if (st0 !== RST_ST || st1 !== RST_ST) begin
            n_err++;
            $display("FAIL mid_async got %h/%h want %h", st0, st1, RST_ST);
        end
        #0.5 tb_rst = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h6D;
        step();
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        n_cmp++;
        if ({b0.rd_valid, b0.rd_data} !== 9'h16D) begin
            n_err++;
            $display("FAIL mid_rd_r0 got %h want 16d", {b0.rd_valid, b0.rd_data});
        end
        step();
        n_cmp++;
        if ({b1.rd_valid, b1.rd_data, b0.rd_valid} !== 10'h2DA) begin
            n_err++;
            $display("FAIL mid_rd_r1 got %h want 2da",
                     {b1.rd_valid, b1.rd_data, b0.rd_valid});
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_line_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/line_buf_sync_fifo.md
# line_buf_sync_fifo

Parametrised single-clock line-buffer FIFO for the video/pixel pipeline. It generalises the 1-bit line buffer to any data width and depth, with an optional output register stage. It adds programmable almost-full/almost-empty thresholds, a live water level, a whole-line-available flag and sticky overflow/underflow errors. It sits between a line producer (e.g. a binarisation or filter stage) and a consumer that reads one line at a time.

## Interface
- DATA_W, 8, data word width (1..64)
- ADDR_W, 10, depth = 2**ADDR_W words
- OUTPUT_REG, 0, 0: read data one cycle after accepted read; 1: two cycles
- ALMOST_FULL_NUM, 1020, almost_full asserted when level >= this
- ALMOST_EMPTY_NUM, 4, almost_empty asserted when level <= this
- LINE_LEN, 640, words per line; 1..2**ADDR_W
- clk  in  1  clock; all logic on rising edge
- tb_rst  in  1  reset, asynchronous, active-high
- wr_data  in  DATA_W  write word
- wr_en  in  1  write request
- wr_full  out  1  level == 2**ADDR_W
- almost_full  out  1  threshold flag
- rd_en  in  1  read request
- rd_data  out  DATA_W  read word
- rd_valid  out  1  rd_data carries a newly read word this cycle
- rd_empty  out  1  level == 0
- almost_empty  out  1  threshold flag
- water_level  out  ADDR_W+1  stored word count, 0..2**ADDR_W
- line_rdy  out  1  level >= LINE_LEN
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: 2**ADDR_W x DATA_W RAM; wr_ptr and rd_ptr are ADDR_W+1 bits, with the MSB as wrap bit. Full when the pointers differ only in the MSB; empty when they are equal.
- Write accepted = wr_en & !wr_full, with wr_full sampled at the start of the cycle. The word is stored at wr_ptr[ADDR_W-1:0] and wr_ptr increments.
- Read accepted = rd_en & !rd_empty, with rd_empty sampled at the start of the cycle. rd_ptr increments.
- Simultaneous accepted read and write: level unchanged; both pointers advance.
- Write while full is dropped and sets overflow. A read in the same cycle does not rescue the write.
- Read while empty is ignored and sets underflow. A same-cycle write is still accepted.
- Pointers wrap modulo 2**(ADDR_W+1); no special handling at wrap.
- water_level = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1), registered.
- All flags are registered and derived from the next-state level, so they are correct in the cycle after the causing edge.
- overflow and underflow clear only on tb_rst.
- rd_data holds its last value when no read is accepted.

## Timing
- Reset values: rd_data 0, rd_valid 0, rd_empty 1, almost_empty 1, wr_full 0, almost_full 0, line_rdy 0, water_level 0, overflow 0, underflow 0. Pointers are 0.
- Reset mid-operation discards all contents immediately (asynchronously). The first write after reset release is accepted on the first rising edge with tb_rst low.
- Read latency, accepted read at edge N:
  - OUTPUT_REG=0: rd_data and rd_valid update at edge N+1.
  - OUTPUT_REG=1: they update at edge N+2.
  - rd_valid is high for exactly one cycle per accepted read, and is fully pipelined so back-to-back reads give continuous rd_valid.
- Write to read: a word written at edge N makes rd_empty low after edge N+1, so it is readable at edge N+1 at the earliest.
- Full throughput: one write and one read per cycle, sustained.

## Test plan
- Reset and fill:
  - Stimulus: DATA_W=8, ADDR_W=10; hold tb_rst 200 ns, then write 1025 words descending from 0xFF.
  - Required: the first 1024 are accepted; wr_full rises after the 1024th; almost_full rises after the 1020th; the 1025th sets overflow and water_level stays 1024.
- Drain:
  - Stimulus: 1025 consecutive reads with OUTPUT_REG=0.
  - Required: rd_data follows 0xFF, 0xFE, … with wrap modulo 256, one cycle after each read; rd_valid is high for 1024 cycles; underflow is set on the 1025th read; rd_empty=1 and almost_empty=1.
- Register mode: repeat the drain with OUTPUT_REG=1 -> identical data sequence, delayed by exactly two cycles from rd_en.
- Simultaneous operation:
  - At level 0, assert wr_en and rd_en together -> write accepted, read ignored, underflow=1, level=1.
  - At level 1024, assert both -> read accepted, write dropped, overflow=1, level=1023.
- Line flag and wrap:
  - Stimulus: LINE_LEN=640; stream 3000 words while reading continuously after the first 640.
  - Required: line_rdy rises after the 640th write; data order is preserved across pointer wrap; no error flags.
- Mid-operation reset:
  - Stimulus: pulse tb_rst for 1 ns at level 500.
  - Required: all outputs return to their reset values with no clock edge; the next write then read returns that word.
